hedios_client_initiator: RTL

- Client-side (initiator) end of the Hedios packet protocol. It issues one command packet, collects the endpoint's reply packets and reports completion.
- Sits between local request logic and a Hedios packet link: a tx FIFO toward the endpoint and an rx FIFO from it.
- Keeps a register mirror of remote slot updates and of the reported slot/action counts.
- Used for FPGA-to-FPGA links and as the loopback stimulus for endpoint benches.

---
 rtl/hedios_client_initiator.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hedios_client_initiator.sv
// hedios_client_initiator
//   Initiator end of a Hedios packet link. Accepts one local command, pushes it
//   into the tx FIFO and collects the endpoint's replies from the rx FIFO. The
//   transaction ends with a done pulse carrying OK, timeout or remote-error status.
//   Packets that are not replies to the outstanding command are forwarded as
//   events. Slot updates and reported counts are mirrored in registers.
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready/req_command/req_data
//                                    local command request
//   tx_full/tx_command/tx_data/tx_push_packet
//                                    tx FIFO write side
//   rx_empty/rx_command/rx_data/rx_pop_packet
//                                    rx FIFO read side; data is valid after the pop
//   rsp_*                            one pulse per solicited reply
//   evt_*                            one pulse per unsolicited packet
//   slot_wr_*                        mirror write for slot-update replies
//   remote_*                         last reported slot/action counts
//   done/done_status                 completion pulse; 0 OK, 1 timeout, 2 remote error
//   busy                             high whenever a transaction or pop is in progress
module hedios_client_initiator #(
    parameter int SLOT_COUNT     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_command,
    input  logic [31:0] req_data,
    input  logic        tx_full,
    output logic [7:0]  tx_command,
    output logic [31:0] tx_data,
    output logic        tx_push_packet,
    input  logic        rx_empty,
    input  logic [7:0]  rx_command,
    input  logic [31:0] rx_data,
    output logic        rx_pop_packet,
    output logic        rsp_valid,
    output logic [7:0]  rsp_command,
    output logic [31:0] rsp_data,
    output logic        evt_valid,
    output logic [7:0]  evt_command,
    output logic [31:0] evt_data,
    output logic        slot_wr_en,
    output logic [6:0]  slot_wr_idx,
    output logic [31:0] slot_wr_data,
    output logic [7:0]  remote_slot_count,
    output logic [7:0]  remote_var_actions,
    output logic [7:0]  remote_varless_actions,
    output logic        done,
    output logic [1:0]  done_status,
    output logic        busy
);

    localparam logic [7:0]  SLOTS_N  = 8'(SLOT_COUNT);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  STS_OK   = 2'd0;
    localparam logic [1:0]  STS_TMO  = 2'd1;
    localparam logic [1:0]  STS_ERR  = 2'd2;

    // FIN exists only so that a zero-reply command reports done one cycle after its push.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_POP    = 3'd3,
        ST_DECODE = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // Number of replies the endpoint sends for a given command.
    function automatic logic [7:0] reply_count(input logic [7:0] cmd);
        logic [7:0] n;
        if (cmd[7]) begin
            n = 8'd0;
        end else begin
            case (cmd)
                8'h55:   n = 8'd0;
                8'h03:   n = SLOTS_N;
                default: n = 8'd1;
            endcase
        end
        return n;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  remain_q, remain_d;
    logic [31:0] timer_q, timer_d;
    logic        from_idle_q, from_idle_d;
    logic        push_q, push_d;
    logic        pop_q, pop_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_cmd_q, rsp_cmd_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        evt_valid_q, evt_valid_d;
    logic [7:0]  evt_cmd_q, evt_cmd_d;
    logic [31:0] evt_data_q, evt_data_d;
    logic        wr_en_q, wr_en_d;
    logic [6:0]  wr_idx_q, wr_idx_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [7:0]  slot_cnt_q, slot_cnt_d;
    logic [7:0]  var_q, var_d;
    logic [7:0]  varless_q, varless_d;
    logic        done_q, done_d;
    logic [1:0]  status_q, status_d;
    logic        unsolicited_s;
    logic        remote_err_s;

    assign unsolicited_s = from_idle_q || (rx_command == 8'h01) || (rx_command == 8'h04);
    assign remote_err_s  = (rx_command[7:2] == 6'b000010);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        remain_d    = remain_q;
        timer_d     = timer_q;
        from_idle_d = from_idle_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_cmd_d   = rsp_cmd_q;
        rsp_data_d  = rsp_data_q;
        evt_valid_d = 1'b0;
        evt_cmd_d   = evt_cmd_q;
        evt_data_d  = evt_data_q;
        wr_en_d     = 1'b0;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        slot_cnt_d  = slot_cnt_q;
        var_d       = var_q;
        varless_d   = varless_q;
        done_d      = 1'b0;
        status_d    = status_q;
        case (state_q)
            ST_IDLE: begin
                // Draining the rx FIFO wins so a command never goes out over stale packets.
                if (!rx_empty) begin
                    pop_d       = 1'b1;
                    from_idle_d = 1'b1;
                    state_d     = ST_POP;
                end else if (req_valid) begin
                    cmd_d       = req_command;
                    data_d      = req_data;
                    remain_d    = reply_count(req_command);
                    from_idle_d = 1'b0;
                    state_d     = ST_SEND;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SEND: begin
                // The push strobe is registered; as the only writer we cannot refill the FIFO meanwhile.
                if (!tx_full) begin
                    push_d  = 1'b1;
                    timer_d = 32'd0;
                    if (remain_q == 8'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_FIN: begin
                done_d   = 1'b1;
                status_d = STS_OK;
                state_d  = ST_IDLE;
            end
            ST_WAIT: begin
                if (!rx_empty) begin
                    pop_d   = 1'b1;
                    state_d = ST_POP;
                end else if (timer_q == TMO_LAST) begin
                    done_d   = 1'b1;
                    status_d = STS_TMO;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_POP: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (unsolicited_s) begin
                    evt_valid_d = 1'b1;
                    evt_cmd_d   = rx_command;
                    evt_data_d  = rx_data;
                    state_d     = from_idle_q ? ST_IDLE : ST_WAIT;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_cmd_d   = rx_command;
                    rsp_data_d  = rx_data;
                    timer_d     = 32'd0;
                    remain_d    = remain_q - 8'd1;
                    if (rx_command[7]) begin
                        // Out-of-range slot indices are acknowledged but never written.
                        if ({1'b0, rx_command[6:0]} < SLOTS_N) begin
                            wr_en_d   = 1'b1;
                            wr_idx_d  = rx_command[6:0];
                            wr_data_d = rx_data;
                        end else begin
                            wr_en_d   = 1'b0;
                        end
                    end else if (rx_command == 8'h05) begin
                        slot_cnt_d = rx_data[7:0];
                    end else if (rx_command == 8'h06) begin
                        var_d     = rx_data[7:0];
                        varless_d = rx_data[15:8];
                    end else begin
                        slot_cnt_d = slot_cnt_q;
                    end
                    if (remote_err_s) begin
                        done_d   = 1'b1;
                        status_d = STS_ERR;
                        state_d  = ST_IDLE;
                    end else if (remain_q == 8'd1) begin
                        done_d   = 1'b1;
                        status_d = STS_OK;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched command and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'd0;
            data_q      <= 32'd0;
            remain_q    <= 8'd0;
            timer_q     <= 32'd0;
            from_idle_q <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_cmd_q   <= 8'd0;
            rsp_data_q  <= 32'd0;
            evt_valid_q <= 1'b0;
            evt_cmd_q   <= 8'd0;
            evt_data_q  <= 32'd0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= 7'd0;
            wr_data_q   <= 32'd0;
            slot_cnt_q  <= 8'd0;
            var_q       <= 8'd0;
            varless_q   <= 8'd0;
            done_q      <= 1'b0;
            status_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            remain_q    <= remain_d;
            timer_q     <= timer_d;
            from_idle_q <= from_idle_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_cmd_q   <= rsp_cmd_d;
            rsp_data_q  <= rsp_data_d;
            evt_valid_q <= evt_valid_d;
            evt_cmd_q   <= evt_cmd_d;
            evt_data_q  <= evt_data_d;
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            slot_cnt_q  <= slot_cnt_d;
            var_q       <= var_d;
            varless_q   <= varless_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    assign req_ready              = (state_q == ST_IDLE) && rx_empty;
    assign busy                   = (state_q != ST_IDLE);
    assign tx_command             = cmd_q;
    assign tx_data                = data_q;
    assign tx_push_packet         = push_q;
    assign rx_pop_packet          = pop_q;
    assign rsp_valid              = rsp_valid_q;
    assign rsp_command            = rsp_cmd_q;
    assign rsp_data               = rsp_data_q;
    assign evt_valid              = evt_valid_q;
    assign evt_command            = evt_cmd_q;
    assign evt_data               = evt_data_q;
    assign slot_wr_en             = wr_en_q;
    assign slot_wr_idx            = wr_idx_q;
    assign slot_wr_data           = wr_data_q;
    assign remote_slot_count      = slot_cnt_q;
    assign remote_var_actions     = var_q;
    assign remote_varless_actions = varless_q;
    assign done                   = done_q;
    assign done_status            = status_q;

endmodule
